lhca_trng: RTL and testbench
============================

# lhca_trng

Parameterised true-random-number generator built around a linear hybrid cellular automaton (LHCA). Each cell uses rule 90 or rule 150, set per cell, and every step XORs in an external entropy vector, normally driven by `ring_oscillator`. The block runs a warm-up period and a continuous source health test. It serialises LHCA output into words of configurable width and presents them through a valid/ready handshake. It sits between the entropy source and any consumer of random words, such as a key or seed generator.

## Interface
- `WIDTH`, 12: number of LHCA cells, which is also the width of the entropy source.
- `RULE`, `'0`: per-cell rule vector. Bit i = 1 selects rule 150 for cell i; bit i = 0 selects rule 90.
- `OUT_WIDTH`, 32: output word width, from 1 to 64.
- `WARMUP_CYCLES`, 64: number of LHCA steps discarded after enable, at least 1.
- `REP_LIMIT`, 8: number of consecutive identical source samples that triggers a fault, at least 2.

- `clk` input, 1 bit: sole clock; everything is clocked on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `source` input, `WIDTH` bits: entropy vector. It is treated as already synchronised.
- `enable` input, 1 bit: run request.
- `out_data` output, `OUT_WIDTH` bits: random word.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: the consumer accepts the word.
- `fault` output, 1 bit: sticky health-test failure.

## Operation
LHCA step:
- Occurs on every clock edge, regardless of state.
- `next[i] = s[i-1] ^ s[i+1] ^ (RULE[i] & s[i]) ^ source[i]`.
- Null boundary: `s[-1] = s[WIDTH] = 0`.
- If `next` is all zero, the register loads `'d1` instead.
- Reset value of the LHCA register is `'d1`.

FSM states: `IDLE`, `WARMUP`, `COLLECT`, `HOLD`, `FAULT`. Reset state is `IDLE`.
- `IDLE`:
  - Bit counter and warm-up counter are held at 0.
  - `enable = 1` moves to `WARMUP`.
- `WARMUP`:
  - The warm-up counter increments once per cycle.
  - After `WARMUP_CYCLES` cycles in this state, the FSM moves to `COLLECT`.
- `COLLECT`:
  - Each cycle, `s[WIDTH-1]` is shifted into bit 0 of the accumulator, with existing bits moving toward the MSB.
  - When the `OUT_WIDTH`-th bit enters, the FSM moves to `HOLD` and `out_valid` becomes 1.
- `HOLD`:
  - The accumulator is frozen and the LHCA keeps stepping.
  - On a handshake (`out_valid & out_ready`), the FSM returns to `COLLECT` and the bit counter resets to 0.
  - The bit sampled in the handshake cycle is discarded; collection of the next word starts the following cycle.
- `FAULT`:
  - Entered from `WARMUP`, `COLLECT` or `HOLD` when the health test fires.
  - Only `reset` exits this state.
  - `fault` = 1 and `out_valid` = 0.
- `enable = 0` in `WARMUP`, `COLLECT` or `HOLD`:
  - The FSM returns to `IDLE` on the next edge.
  - Any partial word or held word is discarded and `out_valid` drops.
  - The LHCA register is retained.

Health test (repetition count):
- The previous source sample is registered every cycle.
- The counter increments when `source == prev` and clears otherwise.
- The counter is evaluated only outside `IDLE`; it clears in `IDLE`.
- When the counter reaches `REP_LIMIT - 1`, meaning `REP_LIMIT` equal samples in a row, the FSM enters `FAULT` on that edge.
- A fault firing in the same cycle as a handshake takes precedence: the word counts as delivered, but the FSM goes to `FAULT`.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `fault` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Enable-to-first-valid latency: 1 cycle (`IDLE` to `WARMUP`) + `WARMUP_CYCLES` + `OUT_WIDTH` cycles.
- Sustained throughput: one word per `OUT_WIDTH + 1` cycles when `out_ready` is held at 1.
- `out_data` is stable while `out_valid` = 1 and no handshake has occurred.
- `reset` asserted mid-word clears the FSM, all counters and outputs immediately; the LHCA returns to `'d1`.
- Counter widths are `$clog2(max+1)`. The counters never wrap, because every state exits at its terminal count.

## Structure
- Package `lhca_pkg`:
  - state enum `lhca_state_t`;
  - function `lhca_step(state, rule, source)` implementing the step, including the zero-escape.
- Sub-module `lhca_core`:
  - parameters `WIDTH`, `RULE`;
  - ports `clk`, `reset`, `source`, `state`;
  - the register plus `lhca_step`.
- `lhca_trng` contains the FSM, counters, accumulator and health test.

## Test plan
All scenarios drive `source` directly from the bench, not from `ring_oscillator`.
- **LHCA step.** `WIDTH=4`, `RULE=4'b0000`, `enable=0`, source held at 0, reset released. Required: state sequence `0001`, `0010`, `0101`, `1000`, `0100`, `1010`, with no fault.
- **Latency.** `WARMUP_CYCLES=4`, `OUT_WIDTH=8`, source incrementing each cycle, `enable` rises at cycle 0. Required: `out_valid` first = 1 at cycle 13, and it stays high with `out_data` stable while `out_ready` = 0 for 10 cycles.
- **Back-to-back.** Same configuration as the latency test, with `out_ready` = 1 constantly. Required: valid pulses exactly 9 cycles apart.
- **Health fault.** `REP_LIMIT=8`, source frozen at `0x5A5` during `COLLECT`. Required:
  - `fault` = 1 on the 8th equal sample;
  - `out_valid` = 0 from then on;
  - the fault persists after the source resumes changing;
  - only `reset` clears it.
- **Abort.** `enable` dropped mid-word, then re-raised. Required:
  - `out_valid` stays 0;
  - the new word arrives after a full warm-up plus `OUT_WIDTH` cycles.
- **Reset mid-HOLD.** `reset` asserted asynchronously mid-cycle. Required: `out_valid`, `fault` and `out_data` are 0 before the next edge.

Source files
------------

// File: rtl/lhca_pkg.sv
// Shared types and the LHCA next-state function for the LHCA-based TRNG.
// The step function works on a fixed maximum width; callers zero-extend their state.
package lhca_pkg;

    localparam int LHCA_MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        COLLECT,
        HOLD,
        FAULT
    } lhca_state_t;

    // Cells above `width` are masked off so both neighbours of the edge cells read as zero.
    function automatic logic [LHCA_MAX_WIDTH-1:0] lhca_step(
        input logic [LHCA_MAX_WIDTH-1:0] state,
        input logic [LHCA_MAX_WIDTH-1:0] rule,
        input logic [LHCA_MAX_WIDTH-1:0] source,
        input int                        width
    );
        logic [LHCA_MAX_WIDTH-1:0] mask;
        logic [LHCA_MAX_WIDTH-1:0] cur;
        logic [LHCA_MAX_WIDTH-1:0] nxt;
        mask = (width >= LHCA_MAX_WIDTH) ? '1
             : ((LHCA_MAX_WIDTH'(1) << width) - LHCA_MAX_WIDTH'(1));
        cur  = state & mask;
        nxt  = ((cur << 1) ^ (cur >> 1) ^ (rule & cur) ^ source) & mask;
        if (nxt == '0) begin
            nxt = LHCA_MAX_WIDTH'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lhca_core.sv
// LHCA register: steps every clock with the external entropy vector mixed in.
module lhca_core #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] RULE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] source,
    output logic [WIDTH-1:0] state
);
    import lhca_pkg::*;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WIDTH'(1);
        end else begin
            state <= WIDTH'(lhca_step(LHCA_MAX_WIDTH'(state), LHCA_MAX_WIDTH'(RULE),
                                      LHCA_MAX_WIDTH'(source), WIDTH));
        end
    end

endmodule

// File: rtl/lhca_trng.sv
// LHCA true-random-number generator: warm-up, repetition-count health test,
// serialisation of the top LHCA cell into words and a valid/ready output.
module lhca_trng #(
    parameter int               WIDTH         = 12,
    parameter logic [WIDTH-1:0] RULE          = '0,
    parameter int               OUT_WIDTH     = 32,
    parameter int               WARMUP_CYCLES = 64,
    parameter int               REP_LIMIT     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     source,
    input  logic                 enable,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 fault
);
    import lhca_pkg::*;

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BIT_W  = $clog2(OUT_WIDTH + 1);
    localparam int REP_W  = $clog2(REP_LIMIT);

    lhca_state_t          fsm_state;
    lhca_state_t          state_next;
    logic [WIDTH-1:0]     lhca_state;
    logic [WIDTH-1:0]     prev_source;
    logic [WARM_W-1:0]    warm_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [REP_W-1:0]     rep_cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic                 running;
    logic                 warm_done;
    logic                 word_done;
    logic                 rep_match;
    logic                 health_fire;
    logic                 handshake;
    logic                 unused_cells;

    lhca_core #(
        .WIDTH (WIDTH),
        .RULE  (RULE)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .source (source),
        .state  (lhca_state)
    );

    // Only the top cell is serialised; the remaining cells exist to feed the automaton.
    assign unused_cells = ^lhca_state;

    assign running     = (fsm_state == WARMUP) || (fsm_state == COLLECT) || (fsm_state == HOLD);
    assign warm_done   = (warm_cnt == WARM_W'(WARMUP_CYCLES - 1));
    assign word_done   = (bit_cnt == BIT_W'(OUT_WIDTH - 1));
    assign rep_match   = (source == prev_source);
    assign health_fire = running && rep_match && (rep_cnt == REP_W'(REP_LIMIT - 2));
    assign handshake   = out_valid & out_ready;
    assign out_data    = acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= state_next;
        end
    end

    // A health fault outranks both a handshake and a dropped enable.
    always_comb begin
        state_next = fsm_state;
        case (fsm_state)
            IDLE:    if (enable) state_next = WARMUP;
            WARMUP:  if (warm_done) state_next = COLLECT;
            COLLECT: if (word_done) state_next = HOLD;
            HOLD:    if (handshake) state_next = COLLECT;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
        if (running) begin
            if (health_fire) begin
                state_next = FAULT;
            end else if (!enable) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            fault     <= 1'b0;
        end else begin
            out_valid <= (state_next == HOLD);
            fault     <= (state_next == FAULT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_source <= '0;
            warm_cnt    <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            acc         <= '0;
        end else begin
            prev_source <= source;
            warm_cnt    <= (fsm_state == WARMUP && !warm_done) ? warm_cnt + 1'b1 : '0;
            case (fsm_state)
                COLLECT: begin
                    acc     <= (acc << 1) | OUT_WIDTH'(lhca_state[WIDTH-1]);
                    bit_cnt <= bit_cnt + 1'b1;
                end
                HOLD: begin
                    if (handshake) begin
                        bit_cnt <= '0;
                    end
                end
                default: bit_cnt <= '0;
            endcase
            if (fsm_state == IDLE || !rep_match) begin
                rep_cnt <= '0;
            end else if (rep_cnt != REP_W'(REP_LIMIT - 1)) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lhca_trng.sv
// Scoreboard bench for lhca_trng: directed scenarios push expected words with their
// arrival cycle; an independent monitor pops and compares whenever a word is presented.
module tb_lhca_trng;

    localparam logic [11:0] MAIN_RULE = 12'hA65;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [11:0] source;
    logic        enable;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        fault;

    logic [3:0]  step_source;
    logic        step_enable;
    logic        step_ready;
    logic [7:0]  step_data;
    logic        step_valid;
    logic        step_fault;

    int          checks;
    int          errors;
    int          cyc;
    int          fz_from;
    int          fz_to;
    logic [11:0] model_s [0:127];
    exp_t        sb [$];

    lhca_trng #(
        .WIDTH(12), .RULE(MAIN_RULE), .OUT_WIDTH(8), .WARMUP_CYCLES(4), .REP_LIMIT(8)
    ) u_dut (
        .clk(clk), .reset(reset), .source(source), .enable(enable),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fault(fault)
    );

    lhca_trng #(
        .WIDTH(4), .RULE(4'b0000), .OUT_WIDTH(8), .WARMUP_CYCLES(4), .REP_LIMIT(8)
    ) u_step (
        .clk(clk), .reset(reset), .source(step_source), .enable(step_enable),
        .out_data(step_data), .out_valid(step_valid), .out_ready(step_ready), .fault(step_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Period number: after the k-th rising edge following reset release, cyc == k.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) cyc = 0;
            else       cyc = cyc + 1;
        end
    end

    function automatic logic [11:0] src_fn(input int k);
        if (k >= fz_from && k <= fz_to) return 12'h5A5;
        return 12'(k + 'h123);
    endfunction

    // Independent cell-by-cell reference with explicit zero padding at both ends.
    function automatic logic [11:0] model_step(input logic [11:0] s, input logic [11:0] src);
        logic [13:0] p;
        logic [11:0] n;
        p = {1'b0, s, 1'b0};
        for (int i = 0; i < 12; i++) begin
            n[i] = p[i] ^ p[i+2] ^ (MAIN_RULE[i] & p[i+1]) ^ src[i];
        end
        if (n == 12'd0) n = 12'd1;
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks = checks + 1;
        if (actual !== required) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input int n);
        repeat (n) begin
            @(negedge clk);
            source    = src_fn(cyc);
            enable    = en;
            out_ready = rdy;
        end
    endtask

    task automatic doReset(input logic en, input logic rdy, input int from, input int to);
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        fz_from    = from;
        fz_to      = to;
        model_s[0] = 12'd1;
        for (int k = 1; k < 128; k++) begin
            model_s[k] = model_step(model_s[k-1], src_fn(k - 1));
        end
        source    = src_fn(0);
        enable    = en;
        out_ready = rdy;
        reset     = 1'b0;
    endtask

    // The word presented in period v holds the top cell of periods v-8 .. v-1, oldest as MSB.
    task automatic expectWord(input int v);
        exp_t e;
        e.data = 8'd0;
        for (int j = 0; j < 8; j++) begin
            e.data = {e.data[6:0], model_s[v - 8 + j][11]};
        end
        e.cyc = v;
        sb.push_back(e);
    endtask

    task automatic midReset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_fault"}, 64'(fault), 64'd0);
        checkOutput({tag, "_data"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        logic       valid_prev;
        logic [7:0] held;
        exp_t       e;
        valid_prev = 1'b0;
        held       = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                valid_prev = 1'b0;
            end else begin
                if (out_valid && !valid_prev) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_word", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("word_data", 64'(out_data), 64'(e.data));
                        checkOutput("word_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end else if (out_valid && valid_prev) begin
                    checkOutput("data_stable", 64'(out_data), 64'(held));
                end
                valid_prev = out_valid;
                held       = out_data;
            end
        end
    end

    initial begin
        logic [3:0] step_exp [0:5];
        step_exp[0] = 4'b0001; step_exp[1] = 4'b0010; step_exp[2] = 4'b0101;
        step_exp[3] = 4'b1000; step_exp[4] = 4'b0100; step_exp[5] = 4'b1010;
        checks      = 0;
        errors      = 0;
        fz_from     = -1;
        fz_to       = -2;
        reset       = 1'b1;
        source      = 12'd0;
        enable      = 1'b0;
        out_ready   = 1'b0;
        step_source = 4'd0;
        step_enable = 1'b0;
        step_ready  = 1'b0;

        $display("[TB] reset values and LHCA step sequence");
        doReset(1'b0, 1'b0, -1, -2);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_fault", 64'(fault), 64'd0);
        checkOutput("step_0", 64'(u_step.u_core.state), 64'(step_exp[0]));
        for (int k = 1; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("step_seq", 64'(u_step.u_core.state), 64'(step_exp[k]));
        end
        checkOutput("step_fault", 64'(step_fault), 64'd0);
        checkOutput("step_valid", 64'(step_valid), 64'd0);
        checkOutput("step_data", 64'(step_data), 64'd0);

        $display("[TB] latency, hold and back-to-back");
        doReset(1'b1, 1'b0, -1, -2);
        expectWord(13);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("valid_before_13", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 11);
        checkOutput("valid_held", 64'(out_valid), 64'd1);
        expectWord(33);
        expectWord(42);
        expectWord(51);
        applyStimulus(1'b1, 1'b1, 28);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("b2b_sb_empty", 64'(sb.size()), 64'd0);
        checkOutput("b2b_fault", 64'(fault), 64'd0);

        $display("[TB] abort and restart");
        doReset(1'b1, 1'b0, -1, -2);
        expectWord(25);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 13);
        checkOutput("abort_valid_24", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("abort_valid_25", 64'(out_valid), 64'd1);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("abort_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] repetition-count health fault");
        doReset(1'b1, 1'b0, 7, 20);
        expectWord(13);
        applyStimulus(1'b1, 1'b0, 14);
        checkOutput("fault_before_8th", 64'(fault), 64'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("fault_at_8th", 64'(fault), 64'd1);
        checkOutput("fault_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 1'b1, 15);
        checkOutput("fault_sticky", 64'(fault), 64'd1);
        checkOutput("fault_valid_late", 64'(out_valid), 64'd0);
        checkOutput("fault_sb_empty", 64'(sb.size()), 64'd0);
        midReset("fault_rst");

        $display("[TB] asynchronous reset during HOLD");
        doReset(1'b1, 1'b0, -1, -2);
        expectWord(13);
        applyStimulus(1'b1, 1'b0, 16);
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_sb_empty", 64'(sb.size()), 64'd0);
        midReset("hold_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
